// File: rtl/wrr_lock_arbiter_pkg.sv
// Shared types for the weighted round-robin lock arbiter.
package wrr_lock_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_RR   = 2'd0,
    ARB_WRR  = 2'd1,
    ARB_PRIO = 2'd2,
    ARB_RSVD = 2'd3
  } arb_mode_e;

endpackage

// File: rtl/wrr_lock_arbiter_rr_pick_from_ptr.sv
// Combinational find-first over a request vector rotated to start at ptr.
module rr_pick_from_ptr #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IW'(cand);
      if (!found && eligible[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Multi-mode (RR / WRR / strict priority) arbiter with registered one-hot
// grant, burst lock until last beat, and per-requester WRR credits.
module wrr_lock_arbiter
  import wrr_lock_arbiter_pkg::*;
#(
  parameter int unsigned nReq    = 4,
  parameter int unsigned wBits   = 4,
  parameter int unsigned LOCK_EN = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      trigger,
  input  logic [1:0]                mode,
  input  logic [nReq-1:0]           request,
  input  logic [nReq-1:0]           last,
  input  logic                      weight_update,
  input  logic [nReq*wBits-1:0]     weights,
  output logic [nReq-1:0]           grant,
  output logic                      grant_valid,
  output logic [$clog2(nReq)-1:0]   grant_idx,
  output logic                      round_done
);

  localparam int unsigned IW = $clog2(nReq);

  arb_mode_e                    mode_e;
  logic [nReq-1:0][wBits-1:0]   weights_arr;
  logic [nReq-1:0][wBits-1:0]   eff_credit;
  logic [nReq-1:0]              weight_nz;
  logic [nReq-1:0]              credit_nz;
  logic [nReq-1:0]              eff_nz;
  logic [nReq-1:0]              eligible;
  logic                         exhausted;
  logic                         locked;
  logic                         arb_evt;
  logic [IW-1:0]                pick_ptr;
  logic                         pick_found;
  logic [IW-1:0]                pick_idx;

  logic [nReq-1:0]              grant_q, grant_d;
  logic [IW-1:0]                grant_idx_q, grant_idx_d;
  logic [IW-1:0]                ptr_q, ptr_d;
  logic [nReq-1:0][wBits-1:0]   credit_q, credit_d;
  logic                         round_done_q, round_done_d;

  assign mode_e      = arb_mode_e'(mode);
  assign weights_arr = weights;

  always_comb begin
    weight_nz = '0;
    credit_nz = '0;
    eff_nz    = '0;
    for (int unsigned i = 0; i < nReq; i++) begin
      weight_nz[i] = |weights_arr[i];
      credit_nz[i] = |credit_q[i];
    end
    // Reload happens in the same cycle the round runs dry, so no idle bubble.
    exhausted  = ~|(request & credit_nz) && |(request & weight_nz);
    eff_credit = exhausted ? weights_arr : credit_q;
    for (int unsigned i = 0; i < nReq; i++) begin
      eff_nz[i] = |eff_credit[i];
    end
    case (mode_e)
      ARB_WRR: eligible = request & eff_nz;
      default: eligible = request;
    endcase
    pick_ptr = (mode_e == ARB_PRIO) ? '0 : ptr_q;
    locked   = (LOCK_EN != 0) && (|grant_q) && request[grant_idx_q] && !last[grant_idx_q];
    arb_evt  = trigger && !locked;
  end

  rr_pick_from_ptr #(
    .N  (nReq),
    .IW (IW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (pick_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    ptr_d        = ptr_q;
    credit_d     = credit_q;
    round_done_d = 1'b0;
    if (arb_evt) begin
      if (pick_found) begin
        grant_d           = '0;
        grant_d[pick_idx] = 1'b1;
        grant_idx_d       = pick_idx;
        ptr_d             = (pick_idx == IW'(nReq - 1)) ? '0 : pick_idx + IW'(1);
        if (mode_e == ARB_WRR) begin
          credit_d = eff_credit;
          if (credit_d[pick_idx] != '0) begin
            credit_d[pick_idx] = credit_d[pick_idx] - wBits'(1);
          end
          round_done_d = exhausted;
        end
      end else begin
        grant_d = '0;
      end
    end
    // A weight reload wins over both the burst decrement and an auto-reload.
    if (weight_update) begin
      credit_d     = weights_arr;
      round_done_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q      <= '0;
      grant_idx_q  <= '0;
      ptr_q        <= '0;
      credit_q     <= weights_arr;
      round_done_q <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      ptr_q        <= ptr_d;
      credit_q     <= credit_d;
      round_done_q <= round_done_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = grant_idx_q;
  assign round_done  = round_done_q;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Bench for wrr_lock_arbiter: a locking and a non-locking instance share stimulus
// and are checked every cycle against an integer-level arbitration model.
module tb_wrr_lock_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        trigger;
  logic [1:0]  mode;
  logic [3:0]  request;
  logic [3:0]  last;
  logic        weight_update;
  logic [15:0] weights;

  logic [3:0]  grant_l, grant_n;
  logic        gv_l, gv_n;
  logic [1:0]  gi_l, gi_n;
  logic        rd_l, rd_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  wrr_lock_arbiter #(.nReq(4), .wBits(4), .LOCK_EN(1)) u_lock (
    .clock (clock), .reset (reset), .trigger (trigger), .mode (mode),
    .request (request), .last (last), .weight_update (weight_update),
    .weights (weights), .grant (grant_l), .grant_valid (gv_l),
    .grant_idx (gi_l), .round_done (rd_l)
  );

  wrr_lock_arbiter #(.nReq(4), .wBits(4), .LOCK_EN(0)) u_nolock (
    .clock (clock), .reset (reset), .trigger (trigger), .mode (mode),
    .request (request), .last (last), .weight_update (weight_update),
    .weights (weights), .grant (grant_n), .grant_valid (gv_n),
    .grant_idx (gi_n), .round_done (rd_n)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: index 0 mirrors the locking instance, 1 the non-locking one.
  int m_credit[2][4];
  int m_ptr[2];
  int m_idx[2];
  bit m_gv[2];
  bit m_rd[2];
  bit model_ok = 1'b0;

  function automatic int wt(input int i);
    return int'((weights >> (4 * i)) & 16'hF);
  endfunction

  task automatic model_step(input int k);
    bit lk;
    bit any_left;
    bit any_w;
    bit reload;
    int use_c[4];
    int start;
    int w;
    int c;
    if (reset) begin
      m_gv[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_rd[k] = 0;
      for (int i = 0; i < 4; i++) m_credit[k][i] = wt(i);
      return;
    end
    lk = (k == 0) && m_gv[k] && request[m_idx[k]] && !last[m_idx[k]];
    m_rd[k] = 0;
    if (trigger && !lk) begin
      any_left = 0; any_w = 0; reload = 0; w = -1;
      for (int i = 0; i < 4; i++) begin
        use_c[i] = m_credit[k][i];
        if (request[i] && m_credit[k][i] > 0) any_left = 1;
        if (request[i] && wt(i) > 0) any_w = 1;
      end
      if (mode == 2'd1 && !any_left && any_w) begin
        reload = 1;
        for (int i = 0; i < 4; i++) use_c[i] = wt(i);
      end
      start = (mode == 2'd2) ? 0 : m_ptr[k];
      for (int j = 0; j < 4; j++) begin
        c = (start + j) % 4;
        if (w < 0 && request[c] && (mode != 2'd1 || use_c[c] > 0)) w = c;
      end
      if (w >= 0) begin
        m_gv[k] = 1; m_idx[k] = w; m_ptr[k] = (w + 1) % 4;
        if (mode == 2'd1) begin
          for (int i = 0; i < 4; i++) m_credit[k][i] = use_c[i];
          if (m_credit[k][w] > 0) m_credit[k][w]--;
          m_rd[k] = reload;
        end
      end else begin
        m_gv[k] = 0;
      end
    end
    if (weight_update) begin
      for (int i = 0; i < 4; i++) m_credit[k][i] = wt(i);
      m_rd[k] = 0;
    end
  endtask

  always @(posedge clock) begin
    model_step(0);
    model_step(1);
    if (reset) model_ok = 1'b1;
  end

  always @(negedge clock) begin
    if (model_ok) begin
      chk("grant_l",  int'(grant_l), m_gv[0] ? (1 << m_idx[0]) : 0);
      chk("valid_l",  int'(gv_l),    int'(m_gv[0]));
      chk("idx_l",    int'(gi_l),    m_idx[0]);
      chk("rdone_l",  int'(rd_l),    int'(m_rd[0]));
      chk("grant_n",  int'(grant_n), m_gv[1] ? (1 << m_idx[1]) : 0);
      chk("valid_n",  int'(gv_n),    int'(m_gv[1]));
      chk("idx_n",    int'(gi_n),    m_idx[1]);
      chk("rdone_n",  int'(rd_n),    int'(m_rd[1]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; trigger = 1'b0; weight_update = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  int rr_exp[5]    = '{0, 1, 2, 3, 0};
  int wrr_exp[15]  = '{0, 1, 2, 3, 0, 1, 0, 1, 2, 3, 0, 1, 0, 0, 1};
  int wu_exp[6]    = '{1, 0, 1, 0, 0, 1};
  int rd_cnt;

  initial begin
    reset = 1'b1; trigger = 1'b0; mode = 2'd0; request = '0; last = '0;
    weight_update = 1'b0; weights = 16'h1123;
    step(2);
    chk("rst_grant", int'(grant_l), 0);
    chk("rst_valid", int'(gv_l), 0);
    chk("rst_idx",   int'(gi_l), 0);
    chk("rst_rdone", int'(rd_l), 0);

    // Plain RR, all requesting, no last beat
    reset = 1'b0; mode = 2'd0; request = 4'hF; last = 4'h0; trigger = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rr_seq_nolock", int'(gi_n), rr_exp[i]);
      chk("rr_lock_hold",  int'(gi_l), 0);
    end

    // WRR with weights idx0..3 = 3,2,1,1
    do_reset();
    mode = 2'd1; request = 4'hF; last = 4'hF; trigger = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk("wrr_seq_l", int'(gi_l), wrr_exp[i]);
      chk("wrr_seq_n", int'(gi_n), wrr_exp[i]);
      chk("wrr_rdone", int'(rd_l), (i == 7 || i == 14) ? 1 : 0);
      if (i < 14) rd_cnt += int'(rd_l);
    end
    chk("wrr_rdone_cnt", rd_cnt, 1);

    // Weight 0 on idx2 masks it permanently in WRR
    trigger = 1'b0; weight_update = 1'b1; weights = 16'h1023;
    step(1);
    weight_update = 1'b0; trigger = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("w0_masked_l", int'(grant_l[2]), 0);
      chk("w0_masked_n", int'(grant_n[2]), 0);
    end

    // weight_update coinciding with a decrementing grant
    weights = 16'h1123;
    do_reset();
    mode = 2'd1; request = 4'b0011; last = 4'hF; trigger = 1'b1; weight_update = 1'b1;
    step(1);
    chk("wu_grant_valid", int'(gv_l), 1);
    chk("wu_grant_idx",   int'(gi_l), 0);
    weight_update = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("wu_seq",   int'(gi_l), wu_exp[i]);
      chk("wu_rdone", int'(rd_l), (i == 5) ? 1 : 0);
    end

    // Burst lock held until last
    do_reset();
    mode = 2'd0; request = 4'b0010; last = 4'b0000; trigger = 1'b1;
    step(1);
    chk("lock_first", int'(gi_l), 1);
    request = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("lock_held", int'(gi_l), 1);
      chk("lock_held_valid", int'(gv_l), 1);
    end
    last = 4'b0010;
    step(1);
    chk("lock_release", int'(gi_l), 2);
    last = 4'b0000;
    step(1);
    chk("lock_on_2", int'(gi_l), 2);

    // Reset in the middle of a locked burst
    reset = 1'b1;
    step(1);
    chk("midrst_grant", int'(grant_l), 0);
    chk("midrst_valid", int'(gv_l), 0);
    chk("midrst_idx",   int'(gi_l), 0);
    reset = 1'b0; request = 4'b1100; trigger = 1'b1;
    step(1);
    chk("post_rst_l", int'(gi_l), 2);
    chk("post_rst_n", int'(gi_n), 2);

    // Strict priority, then idle, then reserved mode behaving as RR
    do_reset();
    mode = 2'd2; request = 4'b1010; last = 4'hF; trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("prio_idx1", int'(gi_l), 1);
    end
    request = 4'b1000;
    step(1);
    chk("prio_idx3", int'(gi_l), 3);
    request = 4'b0000;
    step(1);
    chk("none_valid", int'(gv_l), 0);
    chk("none_idx_hold", int'(gi_l), 3);
    mode = 2'd3; request = 4'hF;
    step(1);
    chk("rsvd_as_rr", int'(gi_l), 0);

    trigger = 1'b0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
